// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / product-accumulator slice:
// operand and product widths, accumulator FSM states, and a width helper.
package mult_pkg;

   localparam int unsigned P_W = 7;
   localparam int unsigned A_W = 4;
   localparam int unsigned B_W = 3;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Smallest accumulator width that sums COUNT products of width p_w exactly.
   function automatic int unsigned acc_w_min(input int unsigned p_w, input int unsigned count);
      return p_w + $clog2(count);
   endfunction

endpackage

// File: rtl/product_accumulator_block_counter.sv
// Counts accepted products within one block; `last` marks the final slot so
// the counter wraps to zero only on the block's closing accept or a clear.
module block_counter #(
   parameter int unsigned COUNT = 4,
   parameter int unsigned CNT_W = $clog2(COUNT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic last
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign last = (cnt_q == CNT_W'(COUNT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive products into one registered result with valid/ready
// on both sides. Define ACC_SAT_EN for saturating add with a sticky ovf flag.
module product_accumulator #(
   parameter int unsigned P_W   = mult_pkg::P_W,
   parameter int unsigned COUNT = 4,
   parameter int unsigned ACC_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [P_W-1:0]   p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   import mult_pkg::*;

   state_e           state_d, state_q;
   logic [ACC_W-1:0] acc_d, acc_q;
   logic [ACC_W-1:0] acc_out_d, acc_out_q;
   logic [ACC_W-1:0] sum;
   logic             accept;
   logic             last;

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign acc_out   = acc_out_q;
   assign accept    = in_valid & in_ready & ~clr;

   block_counter #(
      .COUNT (COUNT)
   ) u_block_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (accept),
      .last  (last)
   );

`ifdef ACC_SAT_EN
   logic [ACC_W:0] sum_full;
   logic           carry;
   logic           ovf_d, ovf_q;

   // Once saturated, every further non-zero add carries again, so acc stays all-ones.
   always_comb begin
      sum_full = {1'b0, acc_q} + {1'b0, ACC_W'(p)};
      carry    = sum_full[ACC_W];
      sum      = carry ? '1 : sum_full[ACC_W-1:0];
   end

   assign ovf = ovf_q;
`else
   assign sum = acc_q + ACC_W'(p);
   assign ovf = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      acc_out_d = acc_out_q;
`ifdef ACC_SAT_EN
      ovf_d     = ovf_q;
`endif
      if (clr) begin
         state_d = ACCUM;
         acc_d   = '0;
`ifdef ACC_SAT_EN
         ovf_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
`ifdef ACC_SAT_EN
                  ovf_d = ovf_q | carry;
`endif
                  if (last) begin
                     acc_out_d = sum;
                     acc_d     = '0;
                     state_d   = HOLD;
                  end else begin
                     acc_d = sum;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_d = ACCUM;
`ifdef ACC_SAT_EN
                  ovf_d   = 1'b0;
`endif
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         acc_out_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         acc_out_q <= acc_out_d;
      end
   end

`ifdef ACC_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: two instances (ACC_W=10 and 8)
// share one stimulus stream; the driver predicts results, a monitor checks them.
module tb_product_accumulator;

   localparam int unsigned COUNT = 4;
`ifdef ACC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       clr       = 1'b0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b0;
   logic [6:0] p         = '0;

   logic       in_ready10, out_valid10, ovf10;
   logic [9:0] acc_out10;
   logic       in_ready8, out_valid8, ovf8;
   logic [7:0] acc_out8;

   always #5 clk = ~clk;

   product_accumulator #(.P_W(7), .COUNT(COUNT), .ACC_W(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready10),
      .p(p), .out_valid(out_valid10), .out_ready(out_ready), .acc_out(acc_out10), .ovf(ovf10)
   );

   product_accumulator #(.P_W(7), .COUNT(COUNT), .ACC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready8),
      .p(p), .out_valid(out_valid8), .out_ready(out_ready), .acc_out(acc_out8), .ovf(ovf8)
   );

   typedef struct {
      int unsigned a10;
      bit          o10;
      int unsigned a8;
      bit          o8;
   } exp_t;

   exp_t sb_q[$];

   // Reference: exact block sum reduced to the accumulator width.
   function automatic int unsigned ref_acc(input int unsigned s, input int unsigned w);
      int unsigned mx;
      mx = (32'd1 << w) - 32'd1;
      if (SAT) return (s > mx) ? mx : s;
      return s & mx;
   endfunction

   function automatic bit ref_ovf(input int unsigned s, input int unsigned w);
      int unsigned mx;
      mx = (32'd1 << w) - 32'd1;
      return SAT && (s > mx);
   endfunction

   // Driver-side model state
   int unsigned m_sum  = 0;
   int unsigned m_cnt  = 0;
   bit          m_hold = 1'b0;
   bit          m_ovf10 = 1'b0;
   bit          m_ovf8  = 1'b0;
   bit          done    = 1'b0;

   task automatic step(input bit v, input int unsigned pv, input bit c, input bit ordy);
      in_valid  = v;
      p         = 7'(pv);
      clr       = c;
      out_ready = ordy;
      @(posedge clk);
      if (c) begin
         m_sum = 0; m_cnt = 0; m_hold = 1'b0; m_ovf10 = 1'b0; m_ovf8 = 1'b0;
      end else if (m_hold) begin
         if (ordy) begin
            m_hold = 1'b0; m_ovf10 = 1'b0; m_ovf8 = 1'b0;
         end
      end else if (v) begin
         m_sum   = m_sum + pv;
         m_cnt   = m_cnt + 1;
         m_ovf10 = ref_ovf(m_sum, 10);
         m_ovf8  = ref_ovf(m_sum, 8);
         if (m_cnt == COUNT) begin
            sb_q.push_back('{ref_acc(m_sum, 10), m_ovf10, ref_acc(m_sum, 8), m_ovf8});
            m_sum  = 0;
            m_cnt  = 0;
            m_hold = 1'b1;
         end
      end
      #1;
   endtask

   task automatic block4(input int unsigned a, b, c, d, input bit ordy);
      step(1'b1, a, 1'b0, ordy);
      step(1'b1, b, 1'b0, ordy);
      step(1'b1, c, 1'b0, ordy);
      step(1'b1, d, 1'b0, ordy);
   endtask

   task automatic idle(input int unsigned n, input bit ordy);
      for (int i = 0; i < int'(n); i++) step(1'b0, 0, 1'b0, ordy);
   endtask

   // Stimulus
   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // basic block: 3x5, 12x3, 9x4, 8x5
      block4(15, 36, 36, 40, 1'b1);
      idle(2, 1'b1);

      // backpressure with a product offered during HOLD
      block4(15, 36, 36, 40, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 105, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);
      block4(1, 1, 1, 1, 1'b1);
      idle(1, 1'b1);

      // bubbles of three idle cycles
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 105, 1'b0, 1'b1);
         idle(3, 1'b1);
      end
      idle(1, 1'b1);

      // back-to-back overflow block
      block4(105, 105, 105, 105, 1'b1);
      idle(2, 1'b1);

      // clear mid-block drops the product that shares the clr cycle
      step(1'b1, 15, 1'b0, 1'b1);
      step(1'b1, 36, 1'b0, 1'b1);
      step(1'b1, 40, 1'b1, 1'b1);
      block4(1, 2, 3, 4, 1'b1);
      idle(2, 1'b1);

      // clear during HOLD discards the pending result
      block4(1, 1, 1, 1, 1'b0);
      idle(2, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      block4(2, 2, 2, 2, 1'b1);
      idle(2, 1'b1);

      // asynchronous reset while holding a result
      block4(5, 5, 5, 5, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      #2;
      rst_n  = 1'b0;
      m_sum  = 0; m_cnt = 0; m_hold = 1'b0; m_ovf10 = 1'b0; m_ovf8 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0,
              $urandom_range(0, 15) * $urandom_range(0, 7),
              $urandom_range(0, 49) == 0,
              $urandom_range(0, 2) != 0);
      end
      idle(3, 1'b1);
      done = 1'b1;
   end

   // Monitor / scoreboard
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   bit          holding = 1'b0;
   int unsigned held10 = 0, held8 = 0, last10 = 0, last8 = 0;
   bit          hovf10 = 1'b0, hovf8 = 1'b0;
   int unsigned wd = 0;
   exp_t        e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         #1;
         chk("rst_out_valid10", 32'(out_valid10), 32'd0);
         chk("rst_out_valid8",  32'(out_valid8),  32'd0);
         chk("rst_acc_out10",   32'(acc_out10),   32'd0);
         chk("rst_acc_out8",    32'(acc_out8),    32'd0);
         chk("rst_in_ready10",  32'(in_ready10),  32'd1);
         chk("rst_in_ready8",   32'(in_ready8),   32'd1);
         chk("rst_ovf8",        32'(ovf8),        32'd0);
         holding = 1'b0;
         last10  = 0;
         last8   = 0;
         wd      = 0;
         sb_q.delete();
      end else if (done) begin
         chk("sb_drained", 32'(sb_q.size()), 32'd0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
         $finish;
      end else begin
         chk("in_ready10",  32'(in_ready10),  32'(!m_hold));
         chk("in_ready8",   32'(in_ready8),   32'(!m_hold));
         chk("out_valid10", 32'(out_valid10), 32'(m_hold));
         chk("out_valid8",  32'(out_valid8),  32'(m_hold));
         chk("ovf10",       32'(ovf10),       32'(m_ovf10));
         chk("ovf8",        32'(ovf8),        32'(m_ovf8));
         if (out_valid10 && !holding) begin
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
               e       = sb_q.pop_front();
               held10  = e.a10;
               held8   = e.a8;
               hovf10  = e.o10;
               hovf8   = e.o8;
               holding = 1'b1;
               wd      = 0;
            end
         end
         if (holding) begin
            chk("acc_out10",    32'(acc_out10), held10);
            chk("acc_out8",     32'(acc_out8),  held8);
            chk("ovf10_result", 32'(ovf10),     32'(hovf10));
            chk("ovf8_result",  32'(ovf8),      32'(hovf8));
            last10 = held10;
            last8  = held8;
            if (out_ready || clr) holding = 1'b0;
         end else begin
            chk("acc_out10_kept", 32'(acc_out10), last10);
            chk("acc_out8_kept",  32'(acc_out8),  last8);
            if (sb_q.size() > 0) begin
               wd++;
               if (wd > 40) begin
                  chk("result_timeout", 32'd0, 32'd1);
                  void'(sb_q.pop_front());
                  wd = 0;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit exceeded");
   end

endmodule
